mux_nto1_pipe: RTL and testbench

Parametrised, pipelined N-to-1 multiplexer with valid qualification and a channel tag. It is the successor to the fixed 4-channel, 4-bit registered mux tree. It generalises width and channel count, adds a round-robin mode that picks among valid inputs, and carries a channel tag alongside the data. It sits in front of the serialiser/consumer logic wherever several valid-qualified byte or nibble streams merge onto one lane.

---
 rtl/mux_nto1_pipe_pkg.sv | 22 ++
 rtl/mux_nto1_pipe_stage.sv | 31 +++
 rtl/mux_nto1_pipe.sv | 121 ++++++++++++
 tb/tb_mux_nto1_pipe.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mux_nto1_pipe_pkg.sv
// mux_pkg: shared constants and helpers for the pipelined N-to-1 mux.
// Holds the mode encodings, a constant clog2 used to size the select,
// and the channel-slice helper that locates channel i in the flattened data bus.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Constant-evaluable ceil(log2(n)); n is expected to be a power of two >= 2.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // LSB position of channel ch inside a flattened {ch[N-1], ..., ch[0]} bus.
  function automatic int ch_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/mux_nto1_pipe_stage.sv
// mux2_stage_reg: registered 2:1 mux stage of the select tree.
// Ports: clk, reset (sync, active-high), sel (1 picks b), a_/b_ data+valid,
//        y_data/y_valid (registered pick), y_tag (registered sel, one channel-index bit).
module mux2_stage_reg #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_valid,
  output logic [DATA_W-1:0] y_data,
  output logic              y_valid,
  output logic              y_tag
);

  always_ff @(posedge clk) begin
    if (reset) begin
      y_data  <= '0;
      y_valid <= 1'b0;
      y_tag   <= 1'b0;
    end else begin
      y_data  <= sel ? b_data  : a_data;
      y_valid <= sel ? b_valid : a_valid;
      y_tag   <= sel;
    end
  end

endmodule

// File: rtl/mux_nto1_pipe.sv
// mux_nto1_pipe: pipelined N-to-1 mux with fixed-select or round-robin choice.
// Ports: clk, reset (sync, active-high), mode, selector, valid_in, data_in (flattened)
//        -> data_out, valid_out, ch_out, all registered, log2(N_CH) cycles after sampling.
module mux_nto1_pipe
  import mux_pkg::*;
#(
  parameter  int DATA_W = 4,
  parameter  int N_CH   = 4,
  localparam int SEL_W  = clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       selector,
  input  logic [N_CH-1:0]        valid_in,
  input  logic [N_CH*DATA_W-1:0] data_in,
  output logic [DATA_W-1:0]      data_out,
  output logic                   valid_out,
  output logic [SEL_W-1:0]       ch_out
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_off;
  logic [SEL_W-1:0] rr_pick;
  logic [SEL_W-1:0] chosen;
  logic [N_CH-1:0]  rot_valid;
  logic             any_valid;

  // Round-robin chooser: rotate valids so rr_ptr lands at bit 0, take the
  // lowest set bit, then rotate the offset back. With nothing valid the
  // offset stays 0, so the pick falls on rr_ptr itself.
  always_comb begin
    rot_valid = '0;
    rr_off    = '0;
    for (int i = 0; i < N_CH; i++) begin
      rot_valid[i] = valid_in[SEL_W'(rr_ptr + SEL_W'(i))];
    end
    // Scan high to low so the lowest set bit is the last one written.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rot_valid[i]) rr_off = SEL_W'(i);
    end
    any_valid = |valid_in;
    rr_pick   = rr_ptr + rr_off;
    chosen    = (mode == MODE_FIXED) ? selector : rr_pick;
  end

  // Pointer advances past the granted channel only when something was valid;
  // the power-of-two channel count makes the SEL_W-bit add wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (mode == MODE_RR && any_valid) begin
      rr_ptr <= rr_pick + SEL_W'(1);
    end
  end

  // Binary select tree. Level k consumes bit k of the choice, delayed k cycles
  // so it lines up with the data that entered alongside it. Each level appends
  // its select bit above the carried word, so the final word is {ch, data}.
  for (genvar k = 0; k < SEL_W; k++) begin : lvl
    localparam int W  = DATA_W + k;
    localparam int NI = N_CH >> k;
    localparam int NO = NI / 2;

    logic [NI-1:0][W-1:0] in_w;
    logic [NI-1:0]        in_v;
    logic [NO-1:0][W:0]   out_w;
    logic [NO-1:0]        out_v;
    logic                 sel;

    if (k == 0) begin : g_src
      for (genvar i = 0; i < NI; i++) begin : g_ch
        assign in_w[i] = data_in[ch_lsb(i, DATA_W) +: DATA_W];
      end
      assign in_v = valid_in;
      assign sel  = chosen[0];
    end else begin : g_src
      logic [k-1:0] sel_sr;

      always_ff @(posedge clk) begin
        if (reset) begin
          sel_sr <= '0;
        end else begin
          sel_sr[0] <= chosen[k];
          for (int i = 1; i < k; i++) begin
            sel_sr[i] <= sel_sr[i-1];
          end
        end
      end

      assign in_w = lvl[k-1].out_w;
      assign in_v = lvl[k-1].out_v;
      assign sel  = sel_sr[k-1];
    end

    for (genvar j = 0; j < NO; j++) begin : g_mux
      logic [W-1:0] y_data;
      logic         y_tag;

      mux2_stage_reg #(.DATA_W(W)) u_stage (
        .clk     (clk),
        .reset   (reset),
        .sel     (sel),
        .a_data  (in_w[2*j]),
        .a_valid (in_v[2*j]),
        .b_data  (in_w[2*j+1]),
        .b_valid (in_v[2*j+1]),
        .y_data  (y_data),
        .y_valid (out_v[j]),
        .y_tag   (y_tag)
      );

      assign out_w[j] = {y_tag, y_data};
    end
  end

  assign data_out  = lvl[SEL_W-1].out_w[0][DATA_W-1:0];
  assign ch_out    = lvl[SEL_W-1].out_w[0][DATA_W +: SEL_W];
  assign valid_out = lvl[SEL_W-1].out_v[0];

endmodule

// File: tb/tb_mux_nto1_pipe.sv
module tb_mux_nto1_pipe;

  localparam int DATA_W = 4;
  localparam int N_CH   = 4;
  localparam int SEL_W  = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   mode;
  logic [SEL_W-1:0]       selector;
  logic [N_CH-1:0]        valid_in;
  logic [N_CH*DATA_W-1:0] data_in;
  logic [DATA_W-1:0]      data_out;
  logic                   valid_out;
  logic [SEL_W-1:0]       ch_out;

  int checks = 0;
  int errors = 0;

  mux_nto1_pipe #(.DATA_W(DATA_W), .N_CH(N_CH)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .selector  (selector),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ch_out    (ch_out)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; outputs read here reflect that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    mode     = 1'b0;
    selector = 2'd1;
    valid_in = 4'hF;
    for (int i = 0; i < 3; i++) begin
      data_in = 16'($urandom);
      tick();
      checks++;
      if ({data_out, valid_out, ch_out} !== 7'd0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got d=%h v=%b ch=%0d, want all 0", i, data_out, valid_out, ch_out);
      end
    end
    reset   = 1'b0;
    data_in = 16'h9E5A;
    tick();
    checks++;
    if ({data_out, valid_out, ch_out} !== 7'd0) begin
      errors++;
      $display("FAIL reset_release_1: got d=%h v=%b ch=%0d, want all 0", data_out, valid_out, ch_out);
    end
    tick();
    // Second cycle after release shows the first post-reset input: channel 1 = 4'h5.
    checks++;
    if ({data_out, valid_out, ch_out} !== {4'h5, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL reset_first_item: got d=%h v=%b ch=%0d, want d=5 v=1 ch=1", data_out, valid_out, ch_out);
    end
  endtask

  task automatic test_fixed_sweep();
    logic [3:0] exp_d [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
    mode     = 1'b0;
    valid_in = 4'b1111;
    data_in  = {4'hD, 4'hC, 4'hB, 4'hA};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) selector = SEL_W'(i);
      tick();
      if (i >= 1) begin
        checks++;
        if ({data_out, valid_out, ch_out} !== {exp_d[i-1], 1'b1, SEL_W'(i-1)}) begin
          errors++;
          $display("FAIL fixed_sweep[%0d]: got d=%h v=%b ch=%0d, want d=%h v=1 ch=%0d",
                   i-1, data_out, valid_out, ch_out, exp_d[i-1], i-1);
        end
      end
    end
  endtask

  task automatic test_fixed_invalid();
    mode     = 1'b0;
    selector = 2'd2;
    valid_in = 4'b1011;
    data_in  = {4'h1, 4'h7, 4'h3, 4'h4};
    tick();
    tick();
    checks++;
    if ({data_out, valid_out, ch_out} !== {4'h7, 1'b0, 2'd2}) begin
      errors++;
      $display("FAIL fixed_invalid: got d=%h v=%b ch=%0d, want d=7 v=0 ch=2", data_out, valid_out, ch_out);
    end
  endtask

  task automatic test_rr_fair_wrap();
    logic [1:0] exp_ch [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd0, 2'd3, 2'd0};
    pulse_reset();
    mode     = 1'b1;
    selector = 2'd3;
    data_in  = {4'hD, 4'hC, 4'hB, 4'hA};
    for (int i = 0; i < 11; i++) begin
      if (i < 6)       valid_in = 4'b1111;
      else if (i < 10) valid_in = 4'b1001;
      tick();
      if (i >= 1) begin
        checks++;
        if ({data_out, valid_out, ch_out} !== {4'hA + 4'(exp_ch[i-1]), 1'b1, exp_ch[i-1]}) begin
          errors++;
          $display("FAIL rr_fair[%0d]: got d=%h v=%b ch=%0d, want d=%h v=1 ch=%0d",
                   i-1, data_out, valid_out, ch_out, 4'hA + 4'(exp_ch[i-1]), exp_ch[i-1]);
        end
      end
    end
  endtask

  task automatic test_rr_idle();
    logic [3:0] vin   [5] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
    logic [1:0] exp_ch[5] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd1};
    logic       exp_v [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    pulse_reset();
    mode    = 1'b1;
    data_in = {4'hD, 4'hC, 4'hB, 4'hA};
    // First grant (channel 1) moves the pointer to 2, then it must sit there.
    for (int i = 0; i < 6; i++) begin
      if (i < 5) valid_in = vin[i];
      tick();
      if (i >= 1) begin
        checks++;
        if ({data_out, valid_out, ch_out} !== {4'hA + 4'(exp_ch[i-1]), exp_v[i-1], exp_ch[i-1]}) begin
          errors++;
          $display("FAIL rr_idle[%0d]: got d=%h v=%b ch=%0d, want d=%h v=%b ch=%0d",
                   i-1, data_out, valid_out, ch_out, 4'hA + 4'(exp_ch[i-1]), exp_v[i-1], exp_ch[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    pulse_reset();
    mode     = 1'b1;
    valid_in = 4'b1111;
    data_in  = {4'hD, 4'hC, 4'hB, 4'hA};
    // Grants 0,1,2 leave the pointer at 3 with two items still in the pipe.
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({data_out, valid_out, ch_out} !== 7'd0) begin
      errors++;
      $display("FAIL midreset_flush_1: got d=%h v=%b ch=%0d, want all 0", data_out, valid_out, ch_out);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({data_out, valid_out, ch_out} !== 7'd0) begin
      errors++;
      $display("FAIL midreset_flush_2: got d=%h v=%b ch=%0d, want all 0", data_out, valid_out, ch_out);
    end
    tick();
    checks++;
    if ({data_out, valid_out, ch_out} !== {4'hA, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL midreset_first_grant: got d=%h v=%b ch=%0d, want d=a v=1 ch=0", data_out, valid_out, ch_out);
    end
  endtask

  initial begin
    reset    = 1'b1;
    mode     = 1'b0;
    selector = '0;
    valid_in = '0;
    data_in  = '0;
    #2;
    test_reset();
    test_fixed_sweep();
    test_fixed_invalid();
    test_rr_fair_wrap();
    test_rr_idle();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
